hyperbus_arbiter: RTL
=====================

Name: hyperbus_arbiter

Overview:
- N-port round-robin arbiter that shares one HyperBus core request interface between several single-word requesters, e.g. a Wishbone bridge plus a DMA or video fetcher.
- Sits between the requesters and the core's adr/dat/mask/rrq/wrq/ready/valid/busy handshake.
- Sequences exactly one outstanding transaction at a time and returns ack or read data to the owning port.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- HBUS_ADDR_WIDTH, 32, core address width.
- HBUS_DATA_WIDTH, 16, core data width; mask width is HBUS_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only with the optional feature.

Ports:
- hbus_clk  in  1  single clock for all logic.
- hbus_rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-port request level, held until ack/err.
- req_we_i  in  NUM_REQ  per-port 1=write, 0=read.
- req_adr_i  in  NUM_REQ*HBUS_ADDR_WIDTH  packed addresses, port 0 in LSBs.
- req_dat_i  in  NUM_REQ*HBUS_DATA_WIDTH  packed write data.
- req_mask_i  in  NUM_REQ*(HBUS_DATA_WIDTH/8)  packed byte masks, 1=masked.
- gnt_o  out  NUM_REQ  one-hot current owner; 0 when idle.
- req_ack_o  out  NUM_REQ  one-cycle completion pulse to the owner.
- req_err_o  out  NUM_REQ  one-cycle timeout pulse; tied 0 without the feature.
- req_dat_o  out  HBUS_DATA_WIDTH  read data, valid with the read ack; held until the next read.
- hbus_adr_o  out  HBUS_ADDR_WIDTH  latched address.
- hbus_dat_o  out  HBUS_DATA_WIDTH  latched write data.
- hbus_mask_o  out  HBUS_DATA_WIDTH/8  latched mask.
- hbus_rrq  out  1  read request pulse.
- hbus_wrq  out  1  write request pulse.
- hbus_dat_i  in  HBUS_DATA_WIDTH  core read data.
- hbus_ready  in  1  core write-complete strobe.
- hbus_valid  in  1  core read-data-valid strobe.
- hbus_busy  in  1  core transaction in progress.

Behaviour:
- Reset values, applied asynchronously on hbus_rst_n low, including mid-transaction:
  - state=IDLE, rr_ptr=NUM_REQ-1.
  - All outputs 0.
  - No completion is reported for an interrupted transaction.
- States are one-hot: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitrate only when |req_i and !hbus_busy.
  - Winner is the first set req_i searching from (rr_ptr+1) mod NUM_REQ upward, with wrap-around.
  - On a win: latch the winner's adr/dat/mask/we into hbus_*_o and the op register, set gnt_o, rr_ptr<=winner, go to ISSUE.
- ISSUE:
  - Exactly one cycle.
  - Assert hbus_wrq if we, else hbus_rrq.
  - Go to WAIT.
  - hbus_ready and hbus_valid are ignored in this cycle.
- WAIT, write op: on hbus_ready, pulse req_ack_o[owner] in the next cycle and go to DONE.
- WAIT, read op: on hbus_valid, register hbus_dat_i into req_dat_o, pulse req_ack_o[owner] together with that data, and go to DONE.
- WAIT, mismatched strobe: the strobe not matching the op (valid during a write, ready during a read) is ignored, including when both strobes are high in the same cycle.
- DONE:
  - Exactly one cycle; the ack pulse is high here.
  - gnt_o is cleared on exit to IDLE.
  - This gives the requester one cycle to drop req_i, so a stale level is never re-granted.
- Latency and throughput:
  - req_i sampled in IDLE at cycle t -> hbus_*rq high at t+1.
  - ack is high the cycle after the core strobe.
  - Minimum 4 cycles per transaction.
- Fairness:
  - With all ports requesting, grants rotate 0,1,..,N-1,0.
  - A port that deasserts and reasserts waits for its turn.
- Requester drops req_i while granted: the transaction still completes and the ack is still pulsed. Holding inputs stable is not required after grant, because all inputs are latched.
- hbus_busy high in IDLE blocks arbitration. It is not consulted in other states.

Optional Feature:
- Macro: HYPERBUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no matching strobe, pulse req_err_o[owner] (no ack) and go to DONE.
  - A matching strobe in the same cycle as expiry wins, giving a normal ack.
- Undefined: no counter; req_err_o is constant 0; WAIT lasts indefinitely.

Decomposition:
- Package hyperbus_pkg holds:
  - one-hot state encodings (4 bits: IDLE=0001, ISSUE=0010, WAIT=0100, DONE=1000);
  - default HBUS address/data widths;
  - default TIMEOUT_CYCLES.
- Sub-module hyperbus_rr_pick: combinational round-robin picker with inputs req vector and rr_ptr, and outputs a one-hot grant and binary index.

Test Plan:
- Single write, port 0: adr=0x0000_0010, dat=0xBEEF, mask=2'b00; core asserts ready 5 cycles after wrq -> hbus_wrq is one pulse with the latched values, req_ack_o=2'b01 for one cycle, gnt_o returns to 0.
- Single read, port 1: adr=0x40; core returns 0x1234 with valid -> req_dat_o=0x1234 coincident with req_ack_o=2'b10; hbus_rrq is one pulse.
- Both ports requesting continuously for 4 transactions -> grant order 0,1,0,1 after reset; no port is granted twice consecutively.
- hbus_busy=1 while req_i=2'b01 -> no rrq/wrq until busy falls; the grant happens the cycle after busy deasserts.
- hbus_rst_n pulled low in WAIT -> all outputs 0 immediately; no ack; after release, port 0 wins first.
- With HYPERBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never responds -> req_err_o[owner] pulses after 16 WAIT cycles, no ack, and the next request is served normally.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types and defaults for the HyperBus requester arbiter.
package hyperbus_pkg;

    localparam int HBUS_ADDR_W_DEF    = 32;
    localparam int HBUS_DATA_W_DEF    = 16;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

endpackage

// File: rtl/hyperbus_rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr_i, wrapping.
module hyperbus_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic found;

    // Two passes: ports above the pointer first, then the wrapped-around ones.
    always_comb begin
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (PTR_W'(i) > rr_ptr_i)) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (PTR_W'(i) <= rr_ptr_i)) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one HyperBus core port between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining HYPERBUS_ARB_TIMEOUT_EN.
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int HBUS_ADDR_WIDTH = HBUS_ADDR_W_DEF,
    parameter int HBUS_DATA_WIDTH = HBUS_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                                   hbus_clk,
    input  logic                                   hbus_rst_n,
    input  logic [NUM_REQ-1:0]                     req_i,
    input  logic [NUM_REQ-1:0]                     req_we_i,
    input  logic [NUM_REQ*HBUS_ADDR_WIDTH-1:0]     req_adr_i,
    input  logic [NUM_REQ*HBUS_DATA_WIDTH-1:0]     req_dat_i,
    input  logic [NUM_REQ*(HBUS_DATA_WIDTH/8)-1:0] req_mask_i,
    output logic [NUM_REQ-1:0]                     gnt_o,
    output logic [NUM_REQ-1:0]                     req_ack_o,
    output logic [NUM_REQ-1:0]                     req_err_o,
    output logic [HBUS_DATA_WIDTH-1:0]             req_dat_o,
    output logic [HBUS_ADDR_WIDTH-1:0]             hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0]             hbus_dat_o,
    output logic [HBUS_DATA_WIDTH/8-1:0]           hbus_mask_o,
    output logic                                   hbus_rrq,
    output logic                                   hbus_wrq,
    input  logic [HBUS_DATA_WIDTH-1:0]             hbus_dat_i,
    input  logic                                   hbus_ready,
    input  logic                                   hbus_valid,
    input  logic                                   hbus_busy
);

    localparam int MASK_W = HBUS_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || (HBUS_DATA_WIDTH % 8) != 0) begin : g_cfg_err
        $error("hyperbus_arbiter: unsupported parameter set");
    end

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   we_q, we_d;
    logic [HBUS_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [HBUS_DATA_WIDTH-1:0] dat_q, dat_d;
    logic [MASK_W-1:0]      mask_q, mask_d;
    logic [HBUS_DATA_WIDTH-1:0] rdat_q, rdat_d;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [PTR_W-1:0]       pick_idx;
    logic [HBUS_ADDR_WIDTH-1:0] sel_adr;
    logic [HBUS_DATA_WIDTH-1:0] sel_dat;
    logic [MASK_W-1:0]      sel_mask;
    logic                   strobe_hit;

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     err_q, err_d;
`endif

    hyperbus_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (pick_gnt),
        .idx_o    (pick_idx)
    );

    always_comb begin
        sel_adr  = '0;
        sel_dat  = '0;
        sel_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_adr  = req_adr_i[i*HBUS_ADDR_WIDTH +: HBUS_ADDR_WIDTH];
                sel_dat  = req_dat_i[i*HBUS_DATA_WIDTH +: HBUS_DATA_WIDTH];
                sel_mask = req_mask_i[i*MASK_W +: MASK_W];
            end
        end
    end

    // Only the strobe matching the latched op can complete it.
    assign strobe_hit = we_q ? hbus_ready : hbus_valid;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        mask_d   = mask_q;
        rdat_d   = rdat_q;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_i && !hbus_busy) begin
                    state_d  = ST_ISSUE;
                    gnt_d    = pick_gnt;
                    rr_ptr_d = pick_idx;
                    we_d     = |(req_we_i & pick_gnt);
                    adr_d    = sel_adr;
                    dat_d    = sel_dat;
                    mask_d   = sel_mask;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (strobe_hit) begin
                    state_d = ST_DONE;
                    ack_d   = gnt_q;
                    if (!we_q) begin
                        rdat_d = hbus_dat_i;
                    end
                end
`ifdef HYPERBUS_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    err_d   = gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= PTR_W'(NUM_REQ - 1);
            gnt_q    <= '0;
            ack_q    <= '0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            mask_q   <= '0;
            rdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            mask_q   <= mask_d;
            rdat_q   <= rdat_d;
        end
    end

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign req_err_o = err_q;
`else
    assign req_err_o = '0;
`endif

    assign gnt_o       = gnt_q;
    assign req_ack_o   = ack_q;
    assign req_dat_o   = rdat_q;
    assign hbus_adr_o  = adr_q;
    assign hbus_dat_o  = dat_q;
    assign hbus_mask_o = mask_q;
    assign hbus_rrq    = (state_q == ST_ISSUE) && !we_q;
    assign hbus_wrq    = (state_q == ST_ISSUE) && we_q;

endmodule
